// File: rtl/inst_loader.sv
// Instruction-memory loader.
// Consumes a byte stream and issues one write per assembled word.
module inst_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         Start,
    input  logic [7:0]   ByteIn,
    input  logic         ByteValid,
    output logic         ByteReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         Busy,
    output logic         Done,
    output logic         Error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0] LIMIT = 17'(1) << A;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [A:0]     addr_q, addr_d;
    logic [7:0]     lo_q, lo_d;
    logic           wr_en_q, wr_en_d;
    logic [A-1:0]   wr_addr_q, wr_addr_d;
    logic [W-1:0]   wr_data_q, wr_data_d;

    logic           accepting;
    logic           hs;
    logic [15:0]    len_full;
    logic [16:0]    addr_next;

    assign accepting = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       (state_q == DATA_LO) || (state_q == DATA_HI);
    assign hs        = ByteValid && accepting;
    assign len_full  = {ByteIn, cnt_q[7:0]};
    assign addr_next = 17'(addr_q) + 17'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    state_d = LEN_LO;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            LEN_LO: begin
                if (hs) begin
                    cnt_d[7:0] = ByteIn;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (hs) begin
                    cnt_d[15:8] = ByteIn;
                    if (len_full == 16'd0)
                        state_d = DONE;
                    else if ({1'b0, len_full} > LIMIT)
                        state_d = ERR;
                    else
                        state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (hs) begin
                    lo_d    = ByteIn;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (hs) begin
                    // Only the low W-8 bits of the high byte belong to the word.
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[A-1:0];
                    wr_data_d = {ByteIn[W-9:0], lo_q};
                    addr_d    = addr_q + 1'b1;
                    state_d   = (addr_next == {1'b0, cnt_q}) ? DONE : DATA_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            lo_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            lo_q      <= lo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ByteReady = accepting;
    assign Busy      = accepting;
    assign Done      = (state_q == DONE);
    assign Error     = (state_q == ERR);
    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;

endmodule

// File: doc/inst_loader.md
# inst_loader

Program loader that fills the processor's instruction memory before execution starts. It takes a byte stream with a valid/ready handshake, reads a 16-bit word count, then assembles each W-bit instruction from two bytes and issues single-cycle write strobes into the instruction RAM. It sits between the test harness or host link and the write port of instruction memory. The fetch side reads that memory combinationally by address.

## Interface
- A, 10, instruction-memory address bits; legal range 1..15
- W, 9, instruction width; legal range 9..16
- Clk  input  1  clock; all state changes on the rising edge
- ResetN  input  1  asynchronous, active-low reset
- Start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR
- ByteIn  input  8  stream data
- ByteValid  input  1  ByteIn is valid
- ByteReady  output  1  loader accepts a byte this cycle
- WrEn  output  1  instruction-memory write strobe, one cycle per word
- WrAddr  output  A  write address
- WrData  output  W  write data
- Busy  output  1  load in progress
- Done  output  1  last load completed; held until the next Start
- Error  output  1  last load rejected because the count exceeded 2**A; held until the next Start

## Operation
- A handshake occurs on any rising edge where ByteValid and ByteReady are both 1. No other byte is consumed.
- States:
  - IDLE: after reset.
  - LEN_LO: count bits 7:0.
  - LEN_HI: count bits 15:8.
  - DATA_LO: instruction bits 7:0.
  - DATA_HI: instruction bits W-1:8, taken from ByteIn[W-9:0]. Higher bits of the byte are ignored.
  - DONE and ERR: terminal states.
- Transitions:
  - IDLE/DONE/ERR to LEN_LO on Start. This clears Done, Error, the address counter and the count.
  - LEN_LO to LEN_HI on a handshake.
  - LEN_HI on a handshake goes to:
    - DONE if the 16-bit count is 0;
    - ERR if the count is greater than 2**A;
    - DATA_LO otherwise.
  - DATA_LO to DATA_HI on a handshake.
  - DATA_HI on a handshake issues a write. It then returns to DATA_LO, or goes to DONE if this was word N.
- ByteReady is 1 exactly in LEN_LO, LEN_HI, DATA_LO and DATA_HI. It does not depend combinationally on ByteValid.
- Busy is 1 exactly in those same four states.
- Start is ignored while Busy. ByteValid is ignored outside the four accepting states.
- Words are written to consecutive addresses 0..N-1. The address counter is A+1 bits wide so that N = 2**A is representable. WrAddr carries its low A bits.
- No write occurs in ERR. The remaining stream bytes are not consumed.
- DONE and ERR do not modify memory. Instruction memory contents are outside this block and survive Start and reset.

## Timing
- Reset values: ByteReady 0, WrEn 0, WrAddr 0, WrData 0, Busy 0, Done 0, Error 0, state IDLE.
- Reset asserted mid-load returns to IDLE immediately. Any write strobe pending for the next edge is dropped, and no partial word is ever written.
- WrEn, WrAddr and WrData are registered. WrEn is 1 for exactly the one cycle after the DATA_HI handshake. WrAddr and WrData are stable in that cycle.
- Write latency is one cycle from the high-byte handshake to the WrEn cycle.
- Back-to-back bytes can be accepted every cycle. At that rate a word is written every two cycles, so a full load takes 2 + 2N handshake cycles.
- Done rises in the same cycle as the final WrEn. For N = 0, Done rises the cycle after the LEN_HI handshake.
- Error rises the cycle after the LEN_HI handshake. ByteReady is 0 from that same cycle.
- After Start in IDLE/DONE/ERR, the next cycle has ByteReady=1, Busy=1, Done=0 and Error=0.
- ByteValid may stay low for any number of cycles in any accepting state. The state, partial word and address hold during such stalls.

## Test plan
- Reset, Start, then stream 03 00 34 01 12 00 FF 01 with ByteValid held 1 (A=10, W=9):
  - writes 0x134@0, 0x012@1, 0x1FF@2, each one-cycle WrEn;
  - Done=1 with the third WrEn;
  - ByteReady=0 and Busy=0 after it.
- Same stream with ByteValid toggling 1/0 every cycle: identical writes and addresses, and no byte is duplicated or skipped.
- Count 00 00: no WrEn; Done=1 on the cycle after the second byte.
- Count 01 04 (0x401, greater than 1024): Error=1 the next cycle, no WrEn, ByteReady=0. A following Start clears Error and begins a fresh load.
- Count 00 04 (1024) with 1024 words: the last write goes to address 0x3FF with no wrap to 0 mid-load, and Done rises after it.
- ResetN pulsed low after the first data byte of word 1 in a 3-word load: all outputs go to reset values and no write to address 1 occurs. A restart writes from address 0.
